// File: rtl/data_wbuf_pkg.sv
// Shared types and constants for the data-side write buffer.
package data_wbuf_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int DW        = 32;
  localparam int CORE_AW   = 30;

  // Address is stored zero-extended to the full core width so the struct is
  // independent of the memory address width chosen at instantiation.
  typedef struct packed {
    logic [CORE_AW-1:0] addr;
    logic [DW-1:0]      data;
    logic               valid;
  } wbuf_entry_t;

endpackage

// File: rtl/data_wbuf_fifo.sv
// Circular write-buffer FIFO with per-entry address compare and youngest-match lookup.
module wbuf_fifo
  import data_wbuf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               push,
  input  logic [CORE_AW-1:0] push_addr,
  input  logic [DW-1:0]      push_data,
  input  logic               pop,
  output logic [CORE_AW-1:0] head_addr,
  output logic [DW-1:0]      head_data,
  input  logic [CORE_AW-1:0] cmp_addr,
  output logic               hit,
  output logic [DW-1:0]      hit_data,
  output logic               empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wbuf_entry_t      entry_reg [DEPTH];
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [PW:0]      count_reg;
  logic [DEPTH-1:0] match;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == FULL_CNT);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head_addr = entry_reg[head_reg].addr;
  assign head_data = entry_reg[head_reg].data;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign match[gi] = entry_reg[gi].valid && (entry_reg[gi].addr == cmp_addr);
  end

  // Walk entries oldest to youngest so the last hit seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_reg + k[PW-1:0];
      if (match[idx]) begin
        hit      = 1'b1;
        hit_data = entry_reg[idx].data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        entry_reg[k] <= '0;
      end
    end else begin
      if (pop_ok) begin
        entry_reg[head_reg].valid <= 1'b0;
        head_reg                  <= head_reg + 1'b1;
      end
      // When full, tail equals head: the push below overrides the pop's invalidate.
      if (push_ok) begin
        entry_reg[tail_reg] <= '{addr: push_addr, data: push_data, valid: 1'b1};
        tail_reg            <= tail_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/data_wbuf.sv
// Data-side write buffer: posted core writes drain to memory when the port is free,
// reads are forwarded from the buffer or, on a miss, take priority on the memory port.
module data_wbuf
  import data_wbuf_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [31:0]   DWDATA,
  output logic [31:0]   DRDATA,
  output logic          MREQ,
  output logic          MWE,
  output logic [AW-1:0] MADDR,
  output logic [31:0]   MWDATA,
  input  logic [31:0]   MRDATA,
  input  logic          FLUSH,
  output logic          EMPTY
);

  logic               rd;
  logic               wr;
  logic               rd_miss;
  logic               drain;
  logic               hit;
  logic               fifo_empty;
  logic [DW-1:0]      hit_data;
  logic [CORE_AW-1:0] core_addr;
  logic [CORE_AW-1:0] head_addr;
  logic [DW-1:0]      head_data;
  logic [DW-1:0]      drdata_reg;
  logic               rd_pend_reg;
  logic               unused_bits;

  assign rd        = DREQ && !DRW;
  assign wr        = DREQ && DRW;
  assign core_addr = {{(CORE_AW-AW){1'b0}}, DADDR[AW-1:0]};

  // Drain already runs whenever the port is free, so FLUSH needs no extra logic.
  assign unused_bits = ^{DADDR[29:AW], head_addr[CORE_AW-1:AW], FLUSH};

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (wr && !RST),
    .push_addr (core_addr),
    .push_data (DWDATA),
    .pop       (drain),
    .head_addr (head_addr),
    .head_data (head_data),
    .cmp_addr  (core_addr),
    .hit       (hit),
    .hit_data  (hit_data),
    .empty     (fifo_empty)
  );

  assign rd_miss = rd && !hit && !RST;
  assign drain   = !RST && !rd_miss && !fifo_empty;
  assign EMPTY   = fifo_empty;

  always_comb begin
    MREQ   = rd_miss || drain;
    MWE    = drain;
    MADDR  = '0;
    MWDATA = '0;
    if (rd_miss) begin
      MADDR = DADDR[AW-1:0];
    end else if (drain) begin
      MADDR  = head_addr[AW-1:0];
      MWDATA = head_data;
    end
  end

  // A miss returns MRDATA one cycle after issue; pass it straight through that
  // cycle and latch it so DRDATA holds afterwards. Hits land via the register.
  assign DRDATA = rd_pend_reg ? MRDATA : drdata_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      drdata_reg  <= '0;
      rd_pend_reg <= 1'b0;
    end else begin
      rd_pend_reg <= rd_miss;
      if (rd && hit) begin
        drdata_reg <= hit_data;
      end else if (rd_pend_reg) begin
        drdata_reg <= MRDATA;
      end
    end
  end

endmodule
